spi_flash_responder: RTL and testbench

Synthesizable SPI NOR-flash responder: the device end of the SoC's XIP SPI flash interface (chip select, clock, controller data out, controller data in). It oversamples the SPI pins with the system clock, decodes READ, RDID and optionally FAST_READ, and serves bytes from a byte-wide synchronous memory port. It is used in simulation and FPGA test harnesses in place of an external flash, so firmware boots through the real XIP path.

---
 rtl/spi_flash_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder (mode 0): oversampled pins, READ / RDID decode, byte-wide memory port.
// Define SPI_FLASH_FAST_READ_EN to also accept FAST_READ (0x0B) with an 8-clock dummy phase.
module spi_flash_responder #(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              cmd_err
);

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
`endif
  localparam logic [ADDR_W-1:0] ADDR_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
`ifdef SPI_FLASH_FAST_READ_EN
    ST_DUMMY  = 3'd3,
`endif
    ST_DATA   = 3'd4,
    ST_ID     = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  state_t state_r, state_next_s;

  logic [1:0]        cs_sync_r, sck_sync_r, mosi_sync_r;
  logic              cs_prev_r, sck_prev_r;
  logic              cs_s, mosi_s, cs_fall_s, sck_rise_s, sck_fall_s;
  logic              cmd_done_s, addr_done_s;
  logic [7:0]        cmd_byte_s;
  logic [23:0]       addr_word_s;
  logic [4:0]        bit_cnt_r;
  logic [22:0]       rx_shift_r;
  logic [6:0]        tx_shift_r;
  logic [7:0]        next_buf_r;
  logic [ADDR_W-1:0] addr_r, mem_addr_r;
  logic              mem_rd_r, rd_pend_r, first_r, miso_r, miso_oe_r, cmd_err_r;
`ifdef SPI_FLASH_FAST_READ_EN
  logic              fast_r, dummy_done_s;
`endif

  // Pin synchronizers and previous-value flops; CS resets "low" so a held-low CS never looks like a fresh fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_r   <= 2'b00;
      sck_sync_r  <= 2'b00;
      mosi_sync_r <= 2'b00;
      cs_prev_r   <= 1'b0;
      sck_prev_r  <= 1'b0;
    end else begin
      cs_sync_r   <= {cs_sync_r[0], spi_cs_n};
      sck_sync_r  <= {sck_sync_r[0], spi_sck};
      mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
      cs_prev_r   <= cs_sync_r[1];
      sck_prev_r  <= sck_sync_r[1];
    end
  end

  assign cs_s        = cs_sync_r[1];
  assign mosi_s      = mosi_sync_r[1];
  assign cs_fall_s   = cs_prev_r & ~cs_s;
  assign sck_rise_s  = ~cs_s & sck_sync_r[1] & ~sck_prev_r;
  assign sck_fall_s  = ~cs_s & ~sck_sync_r[1] & sck_prev_r;
  assign cmd_byte_s  = {rx_shift_r[6:0], mosi_s};
  assign addr_word_s = {rx_shift_r, mosi_s};
  assign cmd_done_s  = (state_r == ST_CMD) && sck_rise_s && (bit_cnt_r == 5'd7);
  assign addr_done_s = (state_r == ST_ADDR) && sck_rise_s && (bit_cnt_r == 5'd23);
`ifdef SPI_FLASH_FAST_READ_EN
  assign dummy_done_s = (state_r == ST_DUMMY) && sck_rise_s && (bit_cnt_r == 5'd7);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a high CS overrides every state.
  always_comb begin
    state_next_s = state_r;
    if (cs_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) state_next_s = ST_CMD;
          else           state_next_s = ST_IDLE;
        end
        ST_CMD: begin
          if (cmd_done_s) begin
            case (cmd_byte_s)
              OP_READ:      state_next_s = ST_ADDR;
              OP_RDID:      state_next_s = ST_ID;
`ifdef SPI_FLASH_FAST_READ_EN
              OP_FAST_READ: state_next_s = ST_ADDR;
`endif
              default:      state_next_s = ST_IGNORE;
            endcase
          end else begin
            state_next_s = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (addr_done_s) begin
`ifdef SPI_FLASH_FAST_READ_EN
            if (fast_r) state_next_s = ST_DUMMY;
            else        state_next_s = ST_DATA;
`else
            state_next_s = ST_DATA;
`endif
          end else begin
            state_next_s = ST_ADDR;
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY: begin
          if (dummy_done_s) state_next_s = ST_DATA;
          else              state_next_s = ST_DUMMY;
        end
`endif
        ST_DATA, ST_ID, ST_IGNORE: state_next_s = state_r;
        default:                   state_next_s = ST_IDLE;
      endcase
    end
  end

  // Shift registers, memory reads and MISO; the fall right after entering DATA/ID is skipped (bit_cnt_r == 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r  <= 5'd0;
      rx_shift_r <= 23'd0;
      tx_shift_r <= 7'd0;
      next_buf_r <= 8'd0;
      addr_r     <= {ADDR_W{1'b0}};
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_rd_r   <= 1'b0;
      rd_pend_r  <= 1'b0;
      first_r    <= 1'b0;
      miso_r     <= 1'b0;
      miso_oe_r  <= 1'b0;
      cmd_err_r  <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_r     <= 1'b0;
`endif
    end else begin
      mem_rd_r  <= 1'b0;
      cmd_err_r <= 1'b0;
      rd_pend_r <= mem_rd_r;
      miso_oe_r <= (state_next_s == ST_DATA) || (state_next_s == ST_ID);
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r  <= 5'd0;
          rx_shift_r <= 23'd0;
          first_r    <= 1'b0;
        end
        ST_CMD: begin
          if (sck_rise_s) begin
            rx_shift_r <= {rx_shift_r[21:0], mosi_s};
            bit_cnt_r  <= bit_cnt_r + 5'd1;
          end
          if (cmd_done_s) begin
            bit_cnt_r <= 5'd0;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_r    <= (cmd_byte_s == OP_FAST_READ);
`endif
            if (state_next_s == ST_ID) begin
              rx_shift_r <= JEDEC_ID[22:0];
              miso_r     <= JEDEC_ID[23];
            end
            if (state_next_s == ST_IGNORE) cmd_err_r <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (sck_rise_s) begin
            rx_shift_r <= {rx_shift_r[21:0], mosi_s};
            bit_cnt_r  <= bit_cnt_r + 5'd1;
          end
          if (addr_done_s) begin
            bit_cnt_r <= 5'd0;
            addr_r    <= addr_word_s[ADDR_W-1:0];
            if (state_next_s == ST_DATA) begin
              mem_rd_r   <= 1'b1;
              mem_addr_r <= addr_word_s[ADDR_W-1:0];
              first_r    <= 1'b1;
            end
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY: begin
          if (sck_rise_s) bit_cnt_r <= bit_cnt_r + 5'd1;
          if (dummy_done_s) begin
            bit_cnt_r  <= 5'd0;
            mem_rd_r   <= 1'b1;
            mem_addr_r <= addr_r;
            first_r    <= 1'b1;
          end
        end
`endif
        ST_DATA: begin
          if (rd_pend_r) begin
            if (first_r) begin
              tx_shift_r <= mem_rdata[6:0];
              miso_r     <= mem_rdata[7];
              first_r    <= 1'b0;
            end else begin
              next_buf_r <= mem_rdata;
            end
          end
          if (sck_rise_s) begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
          end else if (sck_fall_s) begin
            if (bit_cnt_r == 5'd8) begin
              tx_shift_r <= next_buf_r[6:0];
              miso_r     <= next_buf_r[7];
              bit_cnt_r  <= 5'd0;
            end else if (bit_cnt_r != 5'd0) begin
              miso_r     <= tx_shift_r[6];
              tx_shift_r <= {tx_shift_r[5:0], 1'b0};
              if (bit_cnt_r == 5'd1) begin
                mem_rd_r   <= 1'b1;
                mem_addr_r <= addr_r + ADDR_INC;
                addr_r     <= addr_r + ADDR_INC;
              end
            end
          end
        end
        ST_ID: begin
          if (sck_rise_s) begin
            bit_cnt_r <= 5'd1;
          end else if (sck_fall_s && (bit_cnt_r == 5'd1)) begin
            miso_r     <= rx_shift_r[22];
            rx_shift_r <= {rx_shift_r[21:0], 1'b1};
          end
        end
        ST_IGNORE: bit_cnt_r <= 5'd0;
        default:   bit_cnt_r <= 5'd0;
      endcase
      if ((state_next_s != ST_DATA) && (state_next_s != ST_ID)) miso_r <= 1'b0;
    end
  end

  assign spi_miso    = miso_r;
  assign spi_miso_oe = miso_oe_r;
  assign mem_rd      = mem_rd_r;
  assign mem_addr    = mem_addr_r;
  assign cmd_err     = cmd_err_r;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: stimulus queues expected bytes, read addresses and
// cmd_err pulses; monitor processes pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, mem_rd, cmd_err;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .cmd_err(cmd_err)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_data_q[$];
  logic [23:0] exp_addr_q[$];
  logic        exp_err_q[$];
  logic        rx_en = 1'b0;
  logic        chk_quiet = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: unexpected output %0h with nothing queued (t=%0t)", name, act, $time);
  endtask

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    case (a)
      24'h000010: mem_val = 8'hA5;
      24'h000011: mem_val = 8'h5A;
      24'h000012: mem_val = 8'h00;
      24'h000013: mem_val = 8'hFF;
      24'hFFFFFF: mem_val = 8'h12;
      24'h000000: mem_val = 8'h34;
      24'h000100: mem_val = 8'hC3;
      24'h000101: mem_val = 8'h3C;
      default:    mem_val = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Synchronous memory: data valid one clk after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_val(mem_addr);
  end

  // Monitor: memory reads and cmd_err pulses, sampled on the falling clk edge.
  initial begin
    logic prev_rd;
    logic prev_err;
    prev_rd = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        check("mem_rd_gap", 32'(prev_rd), 32'd0);
        if (exp_addr_q.size() == 0) unexpected("mem_rd", 32'(mem_addr));
        else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (cmd_err) begin
        if (exp_err_q.size() == 0) unexpected("cmd_err", 32'(cmd_err));
        else begin
          void'(exp_err_q.pop_front());
          check("cmd_err_single", 32'(prev_err), 32'd0);
        end
      end
      prev_rd = mem_rd;
      prev_err = cmd_err;
    end
  end

  // Monitor: MISO bytes collected on SCK rise, as the controller samples them.
  initial begin
    int         rx_cnt;
    logic [7:0] rx_byte;
    rx_cnt = 0;
    rx_byte = 8'h00;
    forever begin
      @(posedge spi_sck);
      if (chk_quiet) begin
        check("quiet_miso", 32'(spi_miso), 32'd0);
        check("quiet_oe", 32'(spi_miso_oe), 32'd0);
      end
      if (rx_en) begin
        check("miso_oe", 32'(spi_miso_oe), 32'd1);
        rx_byte = {rx_byte[6:0], spi_miso};
        rx_cnt++;
        if (rx_cnt == 8) begin
          rx_cnt = 0;
          if (exp_data_q.size() == 0) unexpected("miso_byte", 32'(rx_byte));
          else check("miso_byte", 32'(rx_byte), 32'(exp_data_q.pop_front()));
        end
      end else begin
        rx_cnt = 0;
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    chk_quiet = 1'b1;
    spi_bits(op, 8);
    spi_bits(a[23:16], 8);
    spi_bits(a[15:8], 8);
    spi_bits(a[7:0], 8);
    chk_quiet = 1'b0;
  endtask

  task automatic read_bytes(input int n);
    rx_en = 1'b1;
    for (int i = 0; i < n; i++) spi_bits(8'h00, 8);
    rx_en = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    check({name, "_data_left"}, 32'(exp_data_q.size()), 32'd0);
    check({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({name, "_err_left"}, 32'(exp_err_q.size()), 32'd0);
    exp_data_q.delete();
    exp_addr_q.delete();
    exp_err_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // READ 0x10, four bytes; the last byte's first fall prefetches 0x14.
    exp_addr_q = '{24'h000010, 24'h000011, 24'h000012, 24'h000013, 24'h000014};
    exp_data_q = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
    cs_begin(); send_hdr(8'h03, 24'h000010); read_bytes(4); cs_end(); drain("read");

    // Address wrap at the top of the address space.
    exp_addr_q = '{24'hFFFFFF, 24'h000000, 24'h000001};
    exp_data_q = '{8'h12, 8'h34};
    cs_begin(); send_hdr(8'h03, 24'hFFFFFF); read_bytes(2); cs_end(); drain("wrap");

    // RDID: JEDEC bytes then all ones; output disabled during the opcode.
    exp_data_q = '{8'hEF, 8'h40, 8'h16, 8'hFF};
    cs_begin(); chk_quiet = 1'b1; spi_bits(8'h9F, 8); chk_quiet = 1'b0;
    read_bytes(4); cs_end(); drain("rdid");

    // Unsupported opcode 0x05, then a normal READ.
    exp_err_q = '{1'b1};
    cs_begin(); chk_quiet = 1'b1; spi_bits(8'h05, 8); spi_bits(8'hAA, 8); spi_bits(8'h55, 8);
    chk_quiet = 1'b0; cs_end(); drain("badop");
    exp_addr_q = '{24'h000010, 24'h000011};
    exp_data_q = '{8'hA5};
    cs_begin(); send_hdr(8'h03, 24'h000010); read_bytes(1); cs_end(); drain("after_badop");

    // Early CS abort three bits into the second byte (mem[0x41] = 0x1B leaves MISO high).
    exp_addr_q = '{24'h000040, 24'h000041, 24'h000042};
    exp_data_q = '{8'h1A};
    cs_begin(); send_hdr(8'h03, 24'h000040); read_bytes(1); spi_bits(8'h00, 3);
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_oe", 32'(spi_miso_oe), 32'd0);
    check("abort_miso", 32'(spi_miso), 32'd0);
    repeat (12) @(negedge clk); drain("abort");
    exp_addr_q = '{24'h000020, 24'h000021};
    exp_data_q = '{8'h7A};
    cs_begin(); send_hdr(8'h03, 24'h000020); read_bytes(1); cs_end(); drain("after_abort");

    // Reference READ at 0x100.
    exp_addr_q = '{24'h000100, 24'h000101, 24'h000102};
    exp_data_q = '{8'hC3, 8'h3C};
    cs_begin(); send_hdr(8'h03, 24'h000100); read_bytes(2); cs_end(); drain("read100");

`ifdef SPI_FLASH_FAST_READ_EN
    exp_addr_q = '{24'h000100, 24'h000101, 24'h000102};
    exp_data_q = '{8'hC3, 8'h3C};
    cs_begin(); send_hdr(8'h0B, 24'h000100);
    chk_quiet = 1'b1; spi_bits(8'h00, 8); chk_quiet = 1'b0;
    read_bytes(2); cs_end(); drain("fast_read");
`else
    exp_err_q = '{1'b1};
    cs_begin(); send_hdr(8'h0B, 24'h000100);
    chk_quiet = 1'b1; spi_bits(8'h00, 8); spi_bits(8'h00, 8); chk_quiet = 1'b0;
    cs_end(); drain("fast_read_off");
`endif

    // Reset mid-transfer with CS held low: nothing resumes until a fresh CS fall.
    exp_addr_q = '{24'h000050, 24'h000051};
    cs_begin(); send_hdr(8'h03, 24'h000050); spi_bits(8'h00, 4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_oe", 32'(spi_miso_oe), 32'd0);
    chk_quiet = 1'b1; spi_bits(8'h03, 8); chk_quiet = 1'b0;
    cs_end(); drain("midrst");
    exp_addr_q = '{24'h000020, 24'h000021};
    exp_data_q = '{8'h7A};
    cs_begin(); send_hdr(8'h03, 24'h000020); read_bytes(1); cs_end(); drain("after_midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
